// File: rtl/cpu_pkg.sv
// Shared definitions for the memory stage: datapath width, default register
// address width and the memory-access FSM state encoding.
package cpu_pkg;

   localparam int DATA_W         = 16;
   localparam int DEF_REG_ADDR_W = 3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } mem_state_t;

endpackage

// File: rtl/mem_access_fsm.sv
// Runs one data-memory access over the req/ack handshake, with a bounded wait
// that forces completion (load data 0, sticky MemFault) when no ack arrives.
module mem_access_fsm
   import cpu_pkg::*;
#(
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              memop,
   input  logic              memread,
   input  logic              memwrite,
   input  logic              MemAck,
   input  logic [DATA_W-1:0] MemRData,
   output logic              MemReq,
   output logic              MemWe,
   output logic              done,
   output logic [DATA_W-1:0] ldata,
   output logic              MemFault
);

   localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

   mem_state_t        state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [DATA_W-1:0] ldata_nxt;
   logic              fault_nxt;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v >= CNT_MAX) ? CNT_MAX : v + 1'b1;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         ldata    <= '0;
         MemFault <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         ldata    <= ldata_nxt;
         MemFault <= fault_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      ldata_nxt = ldata;
      fault_nxt = MemFault;
      MemReq    = 1'b0;
      MemWe     = 1'b0;
      unique case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (memop) state_nxt = ACCESS;
         end
         ACCESS: begin
            MemReq = 1'b1;
            // a load wins when both op bits are latched
            MemWe  = memwrite & ~memread;
            if (MemAck) begin
               ldata_nxt = MemRData;
               state_nxt = DONE;
            end else if (cnt == CNT_MAX) begin
               ldata_nxt = '0;
               fault_nxt = 1'b1;
               state_nxt = DONE;
            end else begin
               cnt_nxt = sat_inc(cnt);
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign done = (state == DONE);

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM register, memory access control, writeback
// selection into the WB register and the forwarding path back to execute.
module mem_stage
   import cpu_pkg::*;
#(
   parameter int REG_ADDR_W = DEF_REG_ADDR_W,
   parameter int TIMEOUT    = 15
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  DivStall,
   input  logic [DATA_W-1:0]     ALUOut,
   input  logic [DATA_W-1:0]     Remainder,
   input  logic [DATA_W-1:0]     DataOut1Out,
   input  logic                  MemRead,
   input  logic                  MemWrite,
   input  logic                  RegWrite,
   input  logic                  SelRem,
   input  logic [REG_ADDR_W-1:0] WriteReg,
   output logic                  MemReq,
   output logic                  MemWe,
   output logic [DATA_W-1:0]     MemAddr,
   output logic [DATA_W-1:0]     MemWData,
   input  logic [DATA_W-1:0]     MemRData,
   input  logic                  MemAck,
   output logic                  MemStall,
   output logic [DATA_W-1:0]     FwdData,
   output logic                  FwdValid,
   output logic [DATA_W-1:0]     WBData,
   output logic [REG_ADDR_W-1:0] WBReg,
   output logic                  WBRegWrite,
   output logic                  MemFault
);

   logic signed [DATA_W-1:0] alu_p0, rem_p0, sdata_p0;
   logic                     rd_p0, wr_p0, rw_p0, selrem_p0;
   logic [REG_ADDR_W-1:0]    wreg_p0;
   logic [DATA_W-1:0]        ldata;
   logic                     memop, done;

   // ---- EX/MEM register ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_p0    <= '0;
         rem_p0    <= '0;
         sdata_p0  <= '0;
         rd_p0     <= 1'b0;
         wr_p0     <= 1'b0;
         rw_p0     <= 1'b0;
         selrem_p0 <= 1'b0;
         wreg_p0   <= '0;
      end else if (!MemStall) begin
         if (DivStall) begin
            rd_p0 <= 1'b0;
            wr_p0 <= 1'b0;
            rw_p0 <= 1'b0;
         end else begin
            alu_p0    <= ALUOut;
            rem_p0    <= Remainder;
            sdata_p0  <= DataOut1Out;
            rd_p0     <= MemRead;
            wr_p0     <= MemWrite;
            rw_p0     <= RegWrite;
            selrem_p0 <= SelRem;
            wreg_p0   <= WriteReg;
         end
      end
   end

   assign memop    = rd_p0 | wr_p0;
   assign MemStall = memop & ~done;
   assign MemAddr  = alu_p0;
   assign MemWData = sdata_p0;
   assign FwdData  = selrem_p0 ? rem_p0 : alu_p0;
   assign FwdValid = rw_p0 & ~rd_p0;

   mem_access_fsm #(
      .TIMEOUT (TIMEOUT)
   ) u_fsm (
      .clk      (clk),
      .rst      (rst),
      .memop    (memop),
      .memread  (rd_p0),
      .memwrite (wr_p0),
      .MemAck   (MemAck),
      .MemRData (MemRData),
      .MemReq   (MemReq),
      .MemWe    (MemWe),
      .done     (done),
      .ldata    (ldata),
      .MemFault (MemFault)
   );

   // ---- WB register ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         WBData     <= '0;
         WBReg      <= '0;
         WBRegWrite <= 1'b0;
      end else if (MemStall) begin
         WBRegWrite <= 1'b0;
      end else begin
         WBRegWrite <= rw_p0;
         WBReg      <= wreg_p0;
         WBData     <= rd_p0 ? ldata : (selrem_p0 ? rem_p0 : alu_p0);
      end
   end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Holds the EX/MEM pipeline register and runs data-memory loads/stores over a req/ack handshake.
- Selects the writeback value (ALU result, divider remainder or load data) and drives the WB pipeline register.
- Supplies a forwarding value back to execute and raises MemStall while a memory access is outstanding.

Parameters:
- REG_ADDR_W, 3, register-file address width.
- TIMEOUT, 15, max cycles MemReq may wait for MemAck before a forced completion (1..255).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- DivStall  in  1  execute stage busy in the divider; its outputs are not valid this cycle.
- ALUOut  in  16  execute result; also the memory address.
- Remainder  in  16  divider remainder.
- DataOut1Out  in  16  store data.
- MemRead  in  1  load.
- MemWrite  in  1  store.
- RegWrite  in  1  instruction writes the register file.
- SelRem  in  1  write back Remainder instead of ALUOut.
- WriteReg  in  REG_ADDR_W  destination register.
- MemReq  out  1  memory request.
- MemWe  out  1  request is a write.
- MemAddr  out  16  memory address.
- MemWData  out  16  memory write data.
- MemRData  in  16  memory read data; valid with MemAck.
- MemAck  in  1  memory completion, one cycle.
- MemStall  out  1  freeze all upstream stages.
- FwdData  out  16  EX/MEM result for forwarding.
- FwdValid  out  1  FwdData may be forwarded.
- WBData  out  16  writeback data.
- WBReg  out  REG_ADDR_W  writeback register.
- WBRegWrite  out  1  writeback enable.
- MemFault  out  1  sticky timeout flag.

Behaviour:
- Reset (async): all registers 0, FSM to IDLE, timeout counter 0, MemFault 0. MemReq drops immediately, including mid-access.
- EX/MEM register advance rules, evaluated each edge:
  - MemStall=1: hold all contents. MemStall has priority over DivStall.
  - Else DivStall=1: load a bubble (MemRead, MemWrite, RegWrite = 0; data fields don't-care).
  - Else: capture all inputs.
- Latched memory op: memop = latched MemRead | MemWrite. Loads take priority if both are set; MemWe=0.
- MemStall (combinational) = memop & (state != DONE).
- FSM states IDLE, ACCESS, DONE:
  - IDLE -> ACCESS when memop; counter cleared.
  - ACCESS: MemReq=1, MemWe=latched MemWrite. MemAddr and MemWData come from the latch and stay stable until ack.
  - ACCESS on MemAck: capture MemRData into the load-data register and go to DONE.
  - ACCESS with counter == TIMEOUT and no ack: load data := 0, MemFault := 1, go to DONE. Otherwise the counter increments.
  - DONE -> IDLE unconditionally; the latch advances on this same edge.
- MemAck outside ACCESS is ignored.
- Minimum memory-op occupancy is 3 cycles: latch edge, request cycle with ack, DONE cycle. Non-memory ops occupy 1 cycle and never stall.
- MemReq=0 in IDLE and DONE; MemAddr/MemWData may still show latch contents.
- WB register:
  - When the EX/MEM latch advances (MemStall=0), load WBRegWrite = latched RegWrite and WBReg = latched WriteReg.
  - WBData = load data if MemRead, else Remainder if SelRem, else ALUOut.
  - When MemStall=1, load a bubble (WBRegWrite=0) and hold WBData/WBReg.
- Forwarding:
  - FwdData = SelRem ? latched Remainder : latched ALUOut.
  - FwdValid = latched RegWrite & ~MemRead.
  - Load results are forwardable only from WB.
- No arithmetic beyond the timeout counter. The counter width is ceil(log2(TIMEOUT+1)) and it saturates at TIMEOUT.
- Store with RegWrite=1 is legal: WBData is ALUOut.
- MemFault clears only on reset.

Decomposition:
- cpu_pkg: FSM state encoding (IDLE, ACCESS, DONE), data width 16, default REG_ADDR_W.
- One sub-module, mem_access_fsm, owning the state register, timeout counter, MemReq/MemWe, load-data capture and MemFault.
- mem_stage keeps the EX/MEM and WB registers plus the writeback and forwarding muxes.

Test Plan:
- ALU op, ALUOut=0x1234, RegWrite=1, WriteReg=5, no stalls -> FwdData=0x1234, FwdValid=1 after edge 1; WBData=0x1234, WBReg=5, WBRegWrite=1 after edge 2; MemStall never high.
- Load, ALUOut=0x0040, MemAck=1 with MemRData=0xBEEF in the first ACCESS cycle:
  - MemStall high for exactly 2 cycles.
  - MemReq=1, MemAddr=0x0040, MemWe=0 for 1 cycle.
  - WBData=0xBEEF the edge after DONE; FwdValid=0 while latched.
- Store, DataOut1Out=0xA5A5, ALUOut=0x0010, ack delayed 4 cycles -> MemReq, MemWe, address and data held stable for 5 cycles; upstream inputs changed during the stall are not captured.
- DivStall=1 for 3 cycles with no memory op -> 3 bubbles (WBRegWrite=0), then the first valid op is captured; DivStall asserted during MemStall has no effect.
- Load with no ack, TIMEOUT=15 -> MemReq high 16 cycles; MemFault=1 thereafter; WBData=0x0000.
- rst asserted mid-ACCESS -> MemReq, MemStall, WBRegWrite go to 0 asynchronously; FSM in IDLE; after release a fresh op runs normally.
